// File: rtl/sigmoid_segment_fetcher_pkg.sv
// Shared widths, LUT geometry and FSM encoding for the sigmoid segment fetcher.
package sigmoid_segment_fetcher_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned IDX_W  = DATA_W - FRAC_W;
    localparam int unsigned DEPTH  = 2 ** IDX_W;

    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdBase,
        StRdNext,
        StCapt,
        StHold
    } state_e;

endpackage

// File: rtl/sigmoid_segment_fetcher.sv
// Splits a signed activation into LUT segment + fraction, fetches the two bounding
// breakpoints with two sequential single-port reads and presents them over valid/ready.
module sigmoid_segment_fetcher
    import sigmoid_segment_fetcher_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_x_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              rom_en_o,
    output logic [IDX_W-1:0]  rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] base_o,
    output logic [DATA_W-1:0] next_data_o,
    output logic [DATA_W-1:0] change_o,
    output logic [DATA_W-1:0] remaining_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic [DATA_W-1:0]   base_tmp_q, base_tmp_d;
    logic [DATA_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   next_data_q, next_data_d;
    logic [DATA_W-1:0]   change_q, change_d;
    logic [DATA_W-1:0]   remaining_q, remaining_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            frac_q      <= '0;
            base_tmp_q  <= '0;
            base_q      <= '0;
            next_data_q <= '0;
            change_q    <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            frac_q      <= frac_d;
            base_tmp_q  <= base_tmp_d;
            base_q      <= base_d;
            next_data_q <= next_data_d;
            change_q    <= change_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        frac_d      = frac_q;
        base_tmp_d  = base_tmp_q;
        base_d      = base_q;
        next_data_d = next_data_q;
        change_d    = change_q;
        remaining_d = remaining_q;
        in_ready_o  = 1'b0;
        rom_en_o    = 1'b0;
        rom_addr_o  = '0;

        case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    // Offset binary: signed index -8..7 becomes address 0..15.
                    addr_d  = {~in_x_i[DATA_W-1], in_x_i[DATA_W-2:FRAC_W]};
                    frac_d  = in_x_i[FRAC_W-1:0];
                    state_d = StRdBase;
                end
            end
            StRdBase: begin
                rom_en_o   = 1'b1;
                rom_addr_o = addr_q;
                state_d    = StRdNext;
            end
            StRdNext: begin
                base_tmp_d = rom_data_i;
                if (addr_q != LAST_ADDR) begin
                    rom_en_o   = 1'b1;
                    rom_addr_o = addr_q + IDX_W'(1);
                end
                state_d = StCapt;
            end
            StCapt: begin
                // Top segment saturates instead of wrapping to address 0.
                base_d      = base_tmp_q;
                next_data_d = (addr_q == LAST_ADDR) ? base_tmp_q : rom_data_i;
                change_d    = next_data_d - base_tmp_q;
                remaining_d = {{(DATA_W-FRAC_W){1'b0}}, frac_q};
                state_d     = StHold;
            end
            StHold: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_valid_o = (state_q == StHold);
    assign base_o      = base_q;
    assign next_data_o = next_data_q;
    assign change_o    = change_q;
    assign remaining_o = remaining_q;

endmodule
